imm_gen_pipe: RTL and testbench

// - Pipelined, parametrised immediate generator for the decode stage: decodes every RV32I/RV64I format
//   (I, I-shift, S, B, U, J, R) to a sign-extended XLEN immediate, a format code and an illegal flag.
// - valid/ready on both sides; a 2-entry skid buffer registers the output so fetch/decode back-pressure

---
 rtl/imm_gen_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator with a 2-entry output skid buffer.
// Decodes RV32I/RV64I immediates (I, ISHIFT, S, B, U, J, R) to a sign-extended XLEN
// value plus format code and illegal flag. The optional compressed (RVC) decode is
// compiled in when the IMMGEN_RVC_EN macro is defined; otherwise 16-bit encodings
// are reported as illegal.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic             out_rvc,
  output logic [TAG_W-1:0] out_tag
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  localparam logic [2:0] FMT_R      = 3'd0;
  localparam logic [2:0] FMT_I      = 3'd1;
  localparam logic [2:0] FMT_S      = 3'd2;
  localparam logic [2:0] FMT_B      = 3'd3;
  localparam logic [2:0] FMT_U      = 3'd4;
  localparam logic [2:0] FMT_J      = 3'd5;
  localparam logic [2:0] FMT_ISHIFT = 3'd6;
  localparam logic [2:0] FMT_NONE   = 3'd7;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic             rvc;
    logic [TAG_W-1:0] tag;
  } entry_t;

  // All formats are first assembled as a signed 32-bit value, then widened here.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic entry_t decode(input logic [31:0] i, input logic [TAG_W-1:0] tag);
    entry_t      e;
    logic [31:0] v;
    e.imm = '0;
    e.fmt = FMT_NONE;
    e.ill = 1'b1;
    e.rvc = 1'b0;
    e.tag = tag;
    v     = '0;
    if (i[1:0] == 2'b11) begin
      e.ill = 1'b0;
      case (i[6:0])
        7'b0010011: begin
          // funct3 001/101 are the shifts; both have funct3[1:0] == 01
          if (i[13:12] == 2'b01) begin
            e.fmt = FMT_ISHIFT;
            v     = (XLEN == 64) ? {26'b0, i[25:20]} : {27'b0, i[24:20]};
          end else begin
            e.fmt = FMT_I;
            v     = {{20{i[31]}}, i[31:20]};
          end
        end
        7'b0000011, 7'b1100111, 7'b1110011: begin
          e.fmt = FMT_I;
          v     = {{20{i[31]}}, i[31:20]};
        end
        7'b0100011: begin
          e.fmt = FMT_S;
          v     = {{20{i[31]}}, i[31:25], i[11:7]};
        end
        7'b1100011: begin
          e.fmt = FMT_B;
          v     = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          e.fmt = FMT_U;
          v     = {i[31:12], 12'b0};
        end
        7'b1101111: begin
          e.fmt = FMT_J;
          v     = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        end
        7'b0110011: e.fmt = FMT_R;
        default: begin
          e.ill = 1'b1;
          e.fmt = FMT_NONE;
        end
      endcase
    end else begin
`ifdef IMMGEN_RVC_EN
      e.rvc = 1'b1;
      e.ill = 1'b0;
      case ({i[1:0], i[15:13]})
        5'b01_000, 5'b01_010: begin  // c.addi / c.li
          e.fmt = FMT_I;
          v     = {{26{i[12]}}, i[12], i[6:2]};
        end
        5'b01_001, 5'b01_101: begin  // c.jal / c.j
          e.fmt = FMT_J;
          v     = {{20{i[12]}}, i[12], i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], 1'b0};
        end
        5'b01_110, 5'b01_111: begin  // c.beqz / c.bnez
          e.fmt = FMT_B;
          v     = {{23{i[12]}}, i[12], i[6:5], i[2], i[11:10], i[4:3], 1'b0};
        end
        5'b00_010: begin             // c.lw
          e.fmt = FMT_I;
          v     = {25'b0, i[5], i[12:10], i[6], 2'b00};
        end
        5'b00_110: begin             // c.sw
          e.fmt = FMT_S;
          v     = {25'b0, i[5], i[12:10], i[6], 2'b00};
        end
        default: begin
          e.ill = 1'b1;
          e.fmt = FMT_NONE;
        end
      endcase
`endif
    end
    if (!e.ill) e.imm = sext32(v);
    return e;
  endfunction

  state_e      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        hd_q, hd_d;
  entry_t      mem_q [2];
  entry_t      mem_d [2];
  entry_t      head;
  logic        accept, pop, wr_idx;

  assign accept    = in_valid & in_ready_q;
  assign out_valid = (state_q != S_EMPTY);
  assign pop       = out_valid & out_ready;
  assign in_ready  = in_ready_q;
  // With one entry held the new write goes behind the head; otherwise it becomes the head.
  assign wr_idx    = (state_q == S_ONE) ? ~hd_q : hd_q;
  assign head      = mem_q[hd_q];

  // Empty buffer shows all-zero outputs so nothing stale leaks after reset or drain.
  assign out_imm     = out_valid ? head.imm : '0;
  assign out_fmt     = out_valid ? head.fmt : 3'd0;
  assign out_illegal = out_valid ? head.ill : 1'b0;
  assign out_rvc     = out_valid ? head.rvc : 1'b0;
  assign out_tag     = out_valid ? head.tag : '0;

  // Occupancy FSM next state, head pointer and registered ready.
  always_comb begin
    state_d = state_q;
    hd_d    = pop ? ~hd_q : hd_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = S_ONE;
      S_ONE: begin
        if (accept && !pop)      state_d = S_TWO;
        else if (pop && !accept) state_d = S_EMPTY;
      end
      S_TWO:   if (pop) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
    in_ready_d = (state_d != S_TWO);
  end

  // Decode the incoming instruction straight into the free buffer slot.
  always_comb begin
    mem_d = mem_q;
    if (accept) mem_d[wr_idx] = decode(in_instr, in_tag);
  end

  // Control registers; reset discards anything held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
      hd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      hd_q       <= hd_d;
    end
  end

  // Entry storage; contents are only visible while the FSM marks them valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed immediates, back-pressure, streaming, reset
// and randomized traffic, scored against a queue-based behavioural model.
module tb_imm_gen_pipe;
  localparam int XLEN  = 32;
  localparam int TAG_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic             out_rvc;
  logic [TAG_W-1:0] out_tag;

  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal),
    .out_rvc(out_rvc), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic             rvc;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference decode written from the encoding tables with integer arithmetic.
  function automatic exp_t model(input logic [31:0] w, input logic [TAG_W-1:0] tg);
    exp_t   e;
    longint s, imm, hi;
    s = longint'($signed(w));
    e.tag = tg; e.rvc = 1'b0; e.ill = 1'b0; e.fmt = 3'd7; imm = 0;
    if (w[1:0] != 2'b11) begin
`ifdef IMMGEN_RVC_EN
      int cq, c3;
      cq = int'(w[1:0]); c3 = int'(w[15:13]);
      e.rvc = 1'b1; e.ill = 1'b1;
      if (cq == 1 && (c3 == 0 || c3 == 2)) begin
        e.fmt = 3'd1; e.ill = 1'b0;
        imm = longint'(w[6:2]) + (w[12] ? -32 : 0);
      end else if (cq == 1 && (c3 == 1 || c3 == 5)) begin
        e.fmt = 3'd5; e.ill = 1'b0;
        imm = (w[12] ? -2048 : 0) + (w[11] ? 16 : 0) + (w[10] ? 512 : 0) + (w[9] ? 256 : 0)
            + (w[8] ? 1024 : 0) + (w[7] ? 64 : 0) + (w[6] ? 128 : 0) + (w[5] ? 8 : 0)
            + (w[4] ? 4 : 0) + (w[3] ? 2 : 0) + (w[2] ? 32 : 0);
      end else if (cq == 1 && (c3 == 6 || c3 == 7)) begin
        e.fmt = 3'd3; e.ill = 1'b0;
        imm = (w[12] ? -256 : 0) + (w[11] ? 16 : 0) + (w[10] ? 8 : 0) + (w[6] ? 128 : 0)
            + (w[5] ? 64 : 0) + (w[4] ? 4 : 0) + (w[3] ? 2 : 0) + (w[2] ? 32 : 0);
      end else if (cq == 0 && (c3 == 2 || c3 == 6)) begin
        e.fmt = (c3 == 2) ? 3'd1 : 3'd2; e.ill = 1'b0;
        imm = (w[12] ? 32 : 0) + (w[11] ? 16 : 0) + (w[10] ? 8 : 0) + (w[6] ? 4 : 0) + (w[5] ? 64 : 0);
      end
`else
      e.ill = 1'b1;
`endif
    end else begin
      case (int'(w[6:0]))
        'h13: begin
          if (w[14:12] == 3'd1 || w[14:12] == 3'd5) begin
            e.fmt = 3'd6;
            imm = (XLEN == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
          end else begin
            e.fmt = 3'd1; imm = s >>> 20;
          end
        end
        'h03, 'h67, 'h73: begin e.fmt = 3'd1; imm = s >>> 20; end
        'h23: begin e.fmt = 3'd2; hi = s >>> 25; imm = hi * 32 + longint'(w[11:7]); end
        'h63: begin
          e.fmt = 3'd3;
          imm = (w[31] ? -4096 : 0) + 2048 * longint'(w[7]) + 32 * longint'(w[30:25]) + 2 * longint'(w[11:8]);
        end
        'h37, 'h17: begin e.fmt = 3'd4; hi = s >>> 12; imm = hi * 4096; end
        'h6F: begin
          e.fmt = 3'd5;
          imm = (w[31] ? -(1 << 20) : 0) + 4096 * longint'(w[19:12]) + 2048 * longint'(w[20])
              + 2 * longint'(w[30:21]);
        end
        'h33: e.fmt = 3'd0;
        default: begin e.ill = 1'b1; e.fmt = 3'd7; end
      endcase
    end
    e.imm = imm[XLEN-1:0];
    return e;
  endfunction

  // Wait for the sampling edge and compare visible state with the model queue.
  task automatic sample();
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("out_imm", 64'(out_imm), 64'(q[0].imm));
      chk("out_fmt", 64'(out_fmt), 64'(q[0].fmt));
      chk("out_illegal", 64'(out_illegal), 64'(q[0].ill));
      chk("out_rvc", 64'(out_rvc), 64'(q[0].rvc));
      chk("out_tag", 64'(out_tag), 64'(q[0].tag));
    end else begin
      chk("idle_outs", {out_imm, out_fmt, out_illegal, out_rvc}, 64'd0);
      chk("idle_tag", 64'(out_tag), 64'd0);
    end
  endtask

  // Apply inputs for the next edge and advance the model as that edge will.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [TAG_W-1:0] tg,
                       input logic ordy, input logic r);
    bit acc, pp;
    in_valid = v; in_instr = ins; in_tag = tg; out_ready = ordy; rst = r;
    if (r) q.delete();
    else begin
      acc = v && (q.size() < 2);
      pp  = ordy && (q.size() > 0);
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(model(ins, tg));
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [TAG_W-1:0] tg,
                      input logic ordy, input logic r);
    sample();
    drive(v, ins, tg, ordy, r);
  endtask

  logic [6:0]  ops [10] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
  logic [31:0] d_ins [9];
  logic [31:0] d_imm [9];
  logic [2:0]  d_fmt [9];
  logic        d_ill [9];
  logic        d_rvc [9];

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 11);
    if (k < 10) r[6:0] = ops[k];
    else if (k == 10) r[1:0] = 2'b11;
    else r[1:0] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  initial begin
    d_ins[0] = 32'hFFF00093; d_imm[0] = 32'hFFFFFFFF; d_fmt[0] = 3'd1; d_ill[0] = 0; d_rvc[0] = 0;
    d_ins[1] = 32'hFE112E23; d_imm[1] = 32'hFFFFFFFC; d_fmt[1] = 3'd2; d_ill[1] = 0; d_rvc[1] = 0;
    d_ins[2] = 32'h123452B7; d_imm[2] = 32'h12345000; d_fmt[2] = 3'd4; d_ill[2] = 0; d_rvc[2] = 0;
    d_ins[3] = 32'hFF9FF06F; d_imm[3] = 32'hFFFFFFF8; d_fmt[3] = 3'd5; d_ill[3] = 0; d_rvc[3] = 0;
    d_ins[4] = 32'h01F09093; d_imm[4] = 32'd31;       d_fmt[4] = 3'd6; d_ill[4] = 0; d_rvc[4] = 0;
    d_ins[5] = 32'h0000007F; d_imm[5] = 32'd0;        d_fmt[5] = 3'd7; d_ill[5] = 1; d_rvc[5] = 0;
    d_ins[6] = 32'hFE000EE3; d_imm[6] = 32'hFFFFFFFC; d_fmt[6] = 3'd3; d_ill[6] = 0; d_rvc[6] = 0;
    d_ins[7] = 32'h003100B3; d_imm[7] = 32'd0;        d_fmt[7] = 3'd0; d_ill[7] = 0; d_rvc[7] = 0;
`ifdef IMMGEN_RVC_EN
    d_ins[8] = 32'h0000557D; d_imm[8] = 32'hFFFFFFFF; d_fmt[8] = 3'd1; d_ill[8] = 0; d_rvc[8] = 1;
`else
    d_ins[8] = 32'h0000557D; d_imm[8] = 32'd0;        d_fmt[8] = 3'd7; d_ill[8] = 1; d_rvc[8] = 0;
`endif

    repeat (2) @(posedge clk);
    sample();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    drive(0, 0, 0, 1, 0);

    // Directed immediates, one at a time, against fixed expected values
    for (int k = 0; k < 9; k++) begin
      step(1, d_ins[k], 32'h1000 + k, 1, 0);
      sample();
      chk($sformatf("dir%0d_imm", k), 64'(out_imm), 64'(d_imm[k]));
      chk($sformatf("dir%0d_fmt", k), 64'(out_fmt), 64'(d_fmt[k]));
      chk($sformatf("dir%0d_ill", k), 64'(out_illegal), 64'(d_ill[k]));
      chk($sformatf("dir%0d_rvc", k), 64'(out_rvc), 64'(d_rvc[k]));
      drive(0, 0, 0, 1, 0);
    end

    // Back-pressure: three offers with out_ready low, then drain
    step(1, 32'hFFF00093, 32'hA1, 0, 0);
    step(1, 32'hFE112E23, 32'hA2, 0, 0);
    step(1, 32'h123452B7, 32'hA3, 0, 0);
    sample();
    chk("bp_full_in_ready", 64'(in_ready), 64'd0);
    chk("bp_head_tag", 64'(out_tag), 64'hA1);
    drive(1, 32'h123452B7, 32'hA3, 1, 0);
    sample();
    chk("bp_pop1_tag", 64'(out_tag), 64'hA2);
    chk("bp_pop1_in_ready", 64'(in_ready), 64'd1);
    drive(1, 32'h123452B7, 32'hA3, 1, 0);
    sample();
    chk("bp_pop2_tag", 64'(out_tag), 64'hA3);
    drive(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Continuous stream with out_ready high: one result per cycle
    for (int k = 0; k < 20; k++) step(1, rand_instr(), 32'hB00 + k, 1, 0);
    step(0, 0, 0, 1, 0);

    // Reset while two entries are held: neither may reappear
    step(1, 32'hFF9FF06F, 32'hC1, 0, 0);
    step(1, 32'h01F09093, 32'hC2, 0, 0);
    step(0, 0, 0, 0, 1);
    sample();
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    drive(0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0);

    // Randomized traffic with occasional reset
    for (int k = 0; k < 600; k++)
      step(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
    step(0, 0, 0, 1, 0);
    sample();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
